uart_tx_arbiter: RTL and testbench

//  Shares the single UART TX write port (TX_data/wr_uart_en/Full) among NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ID_W   = 4;

  localparam logic [BYTE_W-1:0] HDR_ID_MASK = 8'h0F;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } arb_state_t;

  // The id field is masked out of the base, so a base with stray low bits still yields a clean id.
  function automatic logic [BYTE_W-1:0] hdr_byte(input logic [BYTE_W-1:0] base,
                                                  input logic [ID_W-1:0]   id);
    return (base & ~HDR_ID_MASK) | {{(BYTE_W-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, UART TX write port and arbiter status bundled as one interface.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import uart_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      Full;
  logic [BYTE_W-1:0]         TX_data;
  logic                      wr_uart_en;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      timeout_pulse;

  modport master (
    output req_valid, req_data, req_last, Full,
    input  req_ready, TX_data, wr_uart_en, grant_id, busy, timeout_pulse
  );

  modport slave (
    input  req_valid, req_data, req_last, Full,
    output req_ready, TX_data, wr_uart_en, grant_id, busy, timeout_pulse
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  int unsigned j;
  logic        hit;
  logic        found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    hit   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      hit = 1'b0;
      // Constant-index select keeps the scan free of variable-width bit selects.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (i == j) hit = req_i[i];
      end
      if (!found && hit) begin
        found = 1'b1;
        idx_o = ID_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin message arbiter in front of a single UART TX FIFO write port,
// with optional per-message id header and idle-grant timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HDR_EN      = 1,
  parameter logic [7:0]  HDR_BASE    = 8'hA0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
  localparam arb_state_t       GRANT_ST = (HDR_EN != 0) ? HDR : DATA;

  arb_state_t        state_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;
  logic [CNT_W-1:0]  idle_cnt_q;
  logic [CNT_W-1:0]  idle_cnt_d;

  logic [ID_W-1:0]   win_id;
  logic              win_any;
  logic              g_valid;
  logic              g_last;
  logic [BYTE_W-1:0] g_data;
  logic              accept;
  logic              expire;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .idx_o (win_id),
    .any_o (win_any)
  );

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign accept     = (state_q == DATA) && g_valid && !bus.Full;
  assign expire     = (state_q == DATA) && !g_valid && (idle_cnt_q == CNT_LAST);
  assign ptr_d      = (grant_q == ID_LAST) ? '0 : grant_q + 1'b1;
  assign idle_cnt_d = idle_cnt_q + 1'b1;

  always_comb begin
    bus.wr_uart_en = 1'b0;
    bus.TX_data    = '0;
    bus.req_ready  = '0;
    case (state_q)
      HDR: begin
        bus.wr_uart_en = !bus.Full;
        bus.TX_data    = hdr_byte(HDR_BASE, grant_q);
      end
      DATA: begin
        bus.wr_uart_en = accept;
        bus.TX_data    = g_data;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant_q == ID_W'(i)) bus.req_ready[i] = accept;
        end
      end
      default: ;
    endcase
  end

  assign bus.grant_id      = grant_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.timeout_pulse = expire;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      idle_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          idle_cnt_q <= '0;
          if (win_any) begin
            grant_q <= win_id;
            state_q <= GRANT_ST;
          end
        end
        HDR: begin
          if (!bus.Full) state_q <= DATA;
        end
        DATA: begin
          // A Full stall with valid high neither counts nor clears the idle counter.
          if (accept) begin
            idle_cnt_q <= '0;
            if (g_last) begin
              state_q <= IDLE;
              ptr_q   <= ptr_d;
            end
          end else if (expire) begin
            idle_cnt_q <= '0;
            state_q    <= IDLE;
            ptr_q      <= ptr_d;
          end else if (!g_valid) begin
            idle_cnt_q <= idle_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus pushes expected UART bytes, a monitor pops them on each write strobe.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) ifa ();
  uart_tx_arbiter_if #(.NUM_REQ(4)) ifb ();

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .HDR_EN      (1),
    .HDR_BASE    (8'hA0),
    .TIMEOUT_CYC (8)
  ) dut_a (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_a),
    .bus           (ifa)
  );

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .HDR_EN      (0),
    .HDR_BASE    (8'hA0),
    .TIMEOUT_CYC (8)
  ) dut_b (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_b),
    .bus           (ifb)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] src_a [4][$];
  logic [8:0] src_b [4][$];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int         exp_to [$];
  int         wr_cyc_a [$];

  int samp_cyc  = 0;
  int wr_cnt_a  = 0;
  int wr_cnt_b  = 0;
  int first_wr_a = -1;
  int acc_cyc_a = 0;
  int to_seen_a = 0;
  event samp_ev;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Requester driver: presents queue heads at negedge, pops on the ready seen before the edge.
  initial begin
    logic [3:0] rdy_a;
    logic [3:0] rdy_b;
    rdy_a = '0;
    rdy_b = '0;
    ifa.req_valid = '0; ifa.req_data = '0; ifa.req_last = '0; ifa.Full = 1'b0;
    ifb.req_valid = '0; ifb.req_data = '0; ifb.req_last = '0; ifb.Full = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rdy_a[i] && src_a[i].size() > 0) void'(src_a[i].pop_front());
        if (rdy_b[i] && src_b[i].size() > 0) void'(src_b[i].pop_front());
        if (src_a[i].size() > 0) begin
          ifa.req_valid[i] = 1'b1;
          ifa.req_data[i*8 +: 8] = src_a[i][0][7:0];
          ifa.req_last[i] = src_a[i][0][8];
        end else begin
          ifa.req_valid[i] = 1'b0;
          ifa.req_data[i*8 +: 8] = 8'h00;
          ifa.req_last[i] = 1'b0;
        end
        if (src_b[i].size() > 0) begin
          ifb.req_valid[i] = 1'b1;
          ifb.req_data[i*8 +: 8] = src_b[i][0][7:0];
          ifb.req_last[i] = src_b[i][0][8];
        end else begin
          ifb.req_valid[i] = 1'b0;
          ifb.req_data[i*8 +: 8] = 8'h00;
          ifb.req_last[i] = 1'b0;
        end
      end
      #4;
      rdy_a = ifa.req_ready;
      rdy_b = ifb.req_ready;
    end
  end

  // Monitor: samples one time unit before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      samp_cyc++;
      if (ifa.wr_uart_en) begin
        wr_cnt_a++;
        wr_cyc_a.push_back(samp_cyc);
        if (first_wr_a < 0) first_wr_a = samp_cyc;
        check("a_wr_while_full", ifa.Full, 0);
        if (exp_a.size() == 0) check("a_unexpected_wr", ifa.wr_uart_en, 0);
        else check("a_tx_byte", ifa.TX_data, exp_a.pop_front());
      end
      if (ifa.timeout_pulse) begin
        to_seen_a++;
        check("a_timeout_nowrite", ifa.wr_uart_en, 0);
        if (exp_to.size() == 0) check("a_unexpected_timeout", ifa.timeout_pulse, 0);
        else check("a_timeout_latency", samp_cyc - acc_cyc_a, exp_to.pop_front());
      end
      if (|ifa.req_ready) acc_cyc_a = samp_cyc;
      if (ifb.wr_uart_en) begin
        wr_cnt_b++;
        check("b_wr_while_full", ifb.Full, 0);
        if (exp_b.size() == 0) check("b_unexpected_wr", ifb.wr_uart_en, 0);
        else check("b_tx_byte", ifb.TX_data, exp_b.pop_front());
      end
      -> samp_ev;
    end
  end

  task automatic wait_samp(input int n);
    repeat (n) @(samp_ev);
  endtask

  task automatic wait_wr_a(input int target);
    int n = 0;
    while (wr_cnt_a < target && n < 200) begin
      @(samp_ev);
      n++;
    end
    check("a_write_count_reached", wr_cnt_a >= target, 1);
  endtask

  task automatic wait_wr_b(input int target);
    int n = 0;
    while (wr_cnt_b < target && n < 200) begin
      @(samp_ev);
      n++;
    end
    check("b_write_count_reached", wr_cnt_b >= target, 1);
  endtask

  task automatic push_a(input int id, input logic last, input logic [7:0] d);
    src_a[id].push_back({last, d});
  endtask

  task automatic push_b(input int id, input logic last, input logic [7:0] d);
    src_b[id].push_back({last, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int rel;
    int n;

    // Reset with a request pending: no strobe until arbitration after release.
    wait_samp(2);
    push_a(2, 1'b1, 8'h43);
    exp_a.push_back(8'hA2); exp_a.push_back(8'h43);
    wait_samp(2);
    check("rst_busy", ifa.busy, 0);
    check("rst_grant_id", ifa.grant_id, 0);
    check("rst_wr_en", ifa.wr_uart_en, 0);
    check("rst_tx_data", ifa.TX_data, 0);
    check("rst_req_ready", ifa.req_ready, 0);
    check("rst_timeout", ifa.timeout_pulse, 0);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    rel = samp_cyc;
    wait_wr_a(2);
    check("first_strobe_latency", first_wr_a - rel, 2);

    // Two-byte message from requester 1, then a three-way contest from ptr 2.
    wait_samp(2);
    push_a(1, 1'b0, 8'h41); push_a(1, 1'b1, 8'h42);
    exp_a.push_back(8'hA1); exp_a.push_back(8'h41); exp_a.push_back(8'h42);
    wait_wr_a(5);
    wait_samp(2);
    check("msg2_consecutive", wr_cyc_a[4] - wr_cyc_a[2], 2);
    check("msg2_busy_drop", ifa.busy, 0);
    push_a(0, 1'b1, 8'h01); push_a(1, 1'b1, 8'h02); push_a(2, 1'b1, 8'h03);
    exp_a.push_back(8'hA2); exp_a.push_back(8'h03);
    exp_a.push_back(8'hA0); exp_a.push_back(8'h01);
    exp_a.push_back(8'hA1); exp_a.push_back(8'h02);
    wait_wr_a(11);
    wait_samp(2);

    // All four requesting from reset: order 0,1,2,3,0.
    @(negedge clk);
    rst_a = 1'b0;
    wait_samp(2);
    push_a(0, 1'b0, 8'h10); push_a(0, 1'b1, 8'h11); push_a(0, 1'b1, 8'h12);
    push_a(1, 1'b1, 8'h20);
    push_a(2, 1'b0, 8'h30); push_a(2, 1'b1, 8'h31);
    push_a(3, 1'b1, 8'h40);
    exp_a.push_back(8'hA0); exp_a.push_back(8'h10); exp_a.push_back(8'h11);
    exp_a.push_back(8'hA1); exp_a.push_back(8'h20);
    exp_a.push_back(8'hA2); exp_a.push_back(8'h30); exp_a.push_back(8'h31);
    exp_a.push_back(8'hA3); exp_a.push_back(8'h40);
    exp_a.push_back(8'hA0); exp_a.push_back(8'h12);
    @(negedge clk);
    rst_a = 1'b1;
    wait_wr_a(23);
    wait_samp(2);

    // Full held for 5 cycles in DATA after the first data byte.
    push_a(1, 1'b0, 8'h51); push_a(1, 1'b0, 8'h52); push_a(1, 1'b1, 8'h53);
    exp_a.push_back(8'hA1); exp_a.push_back(8'h51);
    exp_a.push_back(8'h52); exp_a.push_back(8'h53);
    wait_wr_a(25);
    @(negedge clk);
    ifa.Full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(samp_ev);
      check("full_wr_en", ifa.wr_uart_en, 0);
      check("full_req_ready", ifa.req_ready, 0);
    end
    @(negedge clk);
    ifa.Full = 1'b0;
    @(samp_ev);
    check("full_release_write", ifa.wr_uart_en, 1);
    wait_wr_a(27);
    wait_samp(2);

    // Requester 0 stalls mid-message: forced release on idle cycle 8, requester 3 next.
    push_a(0, 1'b0, 8'h61);
    exp_a.push_back(8'hA0); exp_a.push_back(8'h61);
    exp_to.push_back(8);
    wait_wr_a(29);
    push_a(3, 1'b1, 8'h71);
    exp_a.push_back(8'hA3); exp_a.push_back(8'h71);
    n = 0;
    while (to_seen_a < 1 && n < 40) begin
      @(samp_ev);
      n++;
    end
    check("timeout_seen", to_seen_a, 1);
    wait_wr_a(31);
    wait_samp(2);

    // No-header instance: reset truncates a message and returns ptr to 0.
    push_b(0, 1'b1, 8'h81);
    exp_b.push_back(8'h81);
    wait_wr_b(1);
    wait_samp(2);
    push_b(1, 1'b0, 8'hC1); push_b(1, 1'b0, 8'hC2);
    push_b(1, 1'b0, 8'hC3); push_b(1, 1'b1, 8'hC4);
    exp_b.push_back(8'hC1); exp_b.push_back(8'hC2);
    wait_wr_b(3);
    @(negedge clk);
    rst_b = 1'b0;
    src_b[1].delete();
    @(samp_ev);
    check("b_rst_busy", ifb.busy, 0);
    check("b_rst_wr_en", ifb.wr_uart_en, 0);
    check("b_rst_tx_data", ifb.TX_data, 0);
    check("b_rst_req_ready", ifb.req_ready, 0);
    check("b_rst_grant_id", ifb.grant_id, 0);
    wait_samp(2);
    @(negedge clk);
    rst_b = 1'b1;
    @(samp_ev);
    push_b(1, 1'b1, 8'hD1);
    push_b(0, 1'b0, 8'hE1); push_b(0, 1'b1, 8'hE2);
    exp_b.push_back(8'hE1); exp_b.push_back(8'hE2); exp_b.push_back(8'hD1);
    wait_wr_b(6);
    wait_samp(3);

    check("a_expected_drained", exp_a.size(), 0);
    check("b_expected_drained", exp_b.size(), 0);
    check("a_timeouts_drained", exp_to.size(), 0);
    check("a_total_writes", wr_cnt_a, 31);
    check("b_total_writes", wr_cnt_b, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
